// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port synchronous memory between the fetch side
//            (I) and the memory-stage side (D). One requester is granted at a
//            time and its access is sequenced IDLE -> ACCESS -> RESP -> IDLE.
//            D has fixed priority. A starvation guard forces an I grant after
//            STARVE_MAX consecutive D grants made while I was waiting.
// Ports    : clk, rst_n (synchronous, active low)
//            I side : i_req, i_addr -> i_rdata, i_ack
//            D side : d_req, d_we, d_addr, d_wdata -> d_rdata, d_ack
//            Memory : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//            ARB_PERF_EN adds perf_i_grants, perf_d_grants, perf_conflicts
// Options  : `define ARB_PERF_EN to add the saturating performance counters
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
`ifdef ARB_PERF_EN
  output logic [31:0]   perf_i_grants,
  output logic [31:0]   perf_d_grants,
  output logic [31:0]   perf_conflicts,
`endif
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int WCW = $clog2(WAIT_CYCLES + 1);
  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [WCW-1:0] c_wait_last  = WCW'(WAIT_CYCLES - 1);
  localparam logic [WCW-1:0] c_wait_one   = WCW'(1);
  localparam logic [SCW-1:0] c_starve_max = SCW'(STARVE_MAX);
  localparam logic [SCW-1:0] c_starve_one = SCW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_owner_d;   // 1: D owns the current access, 0: I
  logic           r_we;
  logic [AW-1:0]  r_addr;
  logic [DW-1:0]  r_wdata;
  logic [WCW-1:0] r_wait;
  logic [SCW-1:0] r_starve;
  logic [DW-1:0]  r_i_rdata;
  logic [DW-1:0]  r_d_rdata;

  logic w_starved;
  logic w_grant;
  logic w_grant_d;
  logic w_wait_last;

  // I is forced only while it is actually waiting and the guard is full.
  assign w_starved   = i_req && (r_starve == c_starve_max);
  assign w_grant_d   = d_req && !w_starved;
  assign w_grant     = (r_state == S_IDLE) && (i_req || d_req);
  assign w_wait_last = (r_wait == c_wait_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_req || d_req) w_next = S_ACCESS;
      S_ACCESS: if (w_wait_last)    w_next = S_RESP;
      S_RESP:                       w_next = S_IDLE;
      default:                      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wait    <= '0;
      r_starve  <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner_d <= w_grant_d;
        r_addr    <= w_grant_d ? d_addr : i_addr;
        r_we      <= w_grant_d && d_we;
        r_wdata   <= w_grant_d ? d_wdata : '0;
        if (w_grant_d) begin
          if (i_req && (r_starve != c_starve_max)) begin
            r_starve <= r_starve + c_starve_one;
          end
        end else begin
          r_starve <= '0;
        end
      end

      if (r_state == S_ACCESS) begin
        r_wait <= w_wait_last ? '0 : (r_wait + c_wait_one);
      end else begin
        r_wait <= '0;
      end

      // Capture at the end of RESP so the value persists between acks.
      if (r_state == S_RESP) begin
        if (!r_owner_d) begin
          r_i_rdata <= mem_rdata;
        end else if (!r_we) begin
          r_d_rdata <= mem_rdata;
        end
      end
    end
  end

`ifdef ARB_PERF_EN
  logic [31:0] r_perf_i;
  logic [31:0] r_perf_d;
  logic [31:0] r_perf_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_i <= '0;
      r_perf_d <= '0;
      r_perf_c <= '0;
    end else if (w_grant) begin
      if (!w_grant_d && (r_perf_i != '1)) r_perf_i <= r_perf_i + 32'd1;
      if (w_grant_d  && (r_perf_d != '1)) r_perf_d <= r_perf_d + 32'd1;
      if (i_req && d_req && (r_perf_c != '1)) r_perf_c <= r_perf_c + 32'd1;
    end
  end

  assign perf_i_grants  = r_perf_i;
  assign perf_d_grants  = r_perf_d;
  assign perf_conflicts = r_perf_c;
`endif

  assign mem_en    = (r_state == S_ACCESS);
  assign mem_we    = (r_state == S_ACCESS) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign i_ack = (r_state == S_RESP) && !r_owner_d;
  assign d_ack = (r_state == S_RESP) &&  r_owner_d;

  // Memory data arrives during RESP; forward it so rdata is valid with ack.
  assign i_rdata = i_ack ? mem_rdata : r_i_rdata;
  assign d_rdata = (d_ack && !r_we) ? mem_rdata : r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Randomized bench for mem_port_arbiter. Two requesters issue
//            random fetches, loads and stores plus occasional resets; a
//            transaction-level timeline model predicts every ack, memory
//            enable window and returned data word.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int W    = 3;
  localparam int SMAX = 4;
  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ack, d_ack;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
`ifdef ARB_PERF_EN
  logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(W), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
`ifdef ARB_PERF_EN
    .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_conflicts(perf_conflicts),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous memory: read data appears the cycle after mem_en.
  logic [31:0] mem [256];
  logic        tb_fill;

  function automatic logic [31:0] init_word(int idx);
    return (idx * 32'h9E3779B1) ^ 32'h5A5A_1234;
  endfunction

  always @(posedge clk) begin
    if (tb_fill) begin
      for (int a = 0; a < 256; a++) mem[a] <= init_word(a);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  int vectors     = 0;
  int miscompares = 0;
  int k           = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, k, got, exp);
    end
  endtask

  // Reference model state (transaction timeline, not an FSM copy)
  logic [31:0] shadow [256];
  int          free_at, ack_at, acc_start, starve;
  bit          active, own_d, t_we;
  logic [31:0] t_addr, t_wdata, t_data;
  logic [31:0] last_i, last_d;
  longint      p_i, p_d, p_c;
  bit          i_busy, d_busy, do_rst;
  bit          exp_iack, exp_dack, exp_en;

  initial begin
    rst_n = 1'b0; tb_fill = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    for (int a = 0; a < 256; a++) shadow[a] = init_word(a);
    repeat (3) @(posedge clk);
    #1;
    tb_fill = 1'b0;
    chk_val("rst_mem_en",   mem_en,    0);
    chk_val("rst_mem_we",   mem_we,    0);
    chk_val("rst_i_ack",    i_ack,     0);
    chk_val("rst_d_ack",    d_ack,     0);
    chk_val("rst_mem_addr", mem_addr,  0);
    chk_val("rst_wdata",    mem_wdata, 0);
    chk_val("rst_i_rdata",  i_rdata,   0);
    chk_val("rst_d_rdata",  d_rdata,   0);
`ifdef ARB_PERF_EN
    chk_val("rst_perf_i", perf_i_grants, 0);
    chk_val("rst_perf_d", perf_d_grants, 0);
    chk_val("rst_perf_c", perf_conflicts, 0);
`endif
    free_at = 0; ack_at = -1; acc_start = -100; starve = 0; active = 0;
    own_d = 0; t_we = 0; t_addr = 0; t_wdata = 0; t_data = 0;
    last_i = 0; last_d = 0; p_i = 0; p_d = 0; p_c = 0;
    i_busy = 0; d_busy = 0;

    for (int n = 0; n < NCYC; n++) begin
      // ---- check outputs of cycle k ----
      exp_iack = active && (ack_at == k) && !own_d;
      exp_dack = active && (ack_at == k) &&  own_d;
      exp_en   = active && (k >= acc_start) && (k < acc_start + W);
      chk_val("i_ack",  i_ack,  exp_iack);
      chk_val("d_ack",  d_ack,  exp_dack);
      chk_val("mem_en", mem_en, exp_en);
      if (exp_en) begin
        chk_val("mem_addr", mem_addr, t_addr);
        chk_val("mem_we",   mem_we,   t_we);
        if (t_we) chk_val("mem_wdata", mem_wdata, t_wdata);
      end
      if (exp_iack) last_i = t_data;
      if (exp_dack && !t_we) last_d = t_data;
      chk_val("i_rdata", i_rdata, last_i);
      chk_val("d_rdata", d_rdata, last_d);
`ifdef ARB_PERF_EN
      chk_val("perf_i", perf_i_grants, p_i);
      chk_val("perf_d", perf_d_grants, p_d);
      chk_val("perf_c", perf_conflicts, p_c);
`endif

      // ---- drive inputs for cycle k ----
      if (i_ack) i_busy = 0;
      if (d_ack) d_busy = 0;
      if (!i_busy && ($urandom_range(0, 9) < 7)) begin
        i_busy = 1;
        i_addr = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 31));
      end
      if (!d_busy && ($urandom_range(0, 9) < 7)) begin
        d_busy  = 1;
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 31));
        d_wdata = $urandom();
      end
      do_rst = ($urandom_range(0, 249) == 0);
      if (do_rst) begin
        rst_n = 0; i_busy = 0; d_busy = 0;
      end else begin
        rst_n = 1;
      end
      i_req = i_busy;
      d_req = d_busy;

      // ---- model decision for cycle k ----
      if (do_rst) begin
        active = 0; ack_at = -1; free_at = k + 1; starve = 0;
        last_i = 0; last_d = 0; p_i = 0; p_d = 0; p_c = 0;
      end else if ((k >= free_at) && (i_req || d_req)) begin
        own_d  = d_req && !(i_req && (starve == SMAX));
        t_addr = own_d ? d_addr : i_addr;
        t_we   = own_d && d_we;
        t_wdata = own_d ? d_wdata : 32'h0;
        if (t_we) shadow[t_addr[7:0]] = t_wdata;
        else      t_data = shadow[t_addr[7:0]];
        if (own_d) begin
          if (i_req && starve < SMAX) starve++;
        end else begin
          starve = 0;
        end
        if (own_d  && p_d < 64'hFFFF_FFFF) p_d++;
        if (!own_d && p_i < 64'hFFFF_FFFF) p_i++;
        if (i_req && d_req && p_c < 64'hFFFF_FFFF) p_c++;
        active    = 1;
        acc_start = k + 1;
        ack_at    = k + W + 1;
        free_at   = k + W + 2;
      end

      @(posedge clk);
      #1;
      k++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
